serial_adder_ctrl: RTL

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one NAND-built full-adder slice reused LSB first, {carry,sum} = A + B + cin.
// done pulses WIDTH+1 edges after the start edge (counting the start edge as edge 1); start is ignored outside IDLE.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_inc;
    logic [WIDTH-1:0] w_sum_nxt;

    // Full-adder slice: two NAND half adders, carries merged by a final NAND.
    logic w_n1, w_n2, w_n3, w_s1;
    logic w_n4, w_n5, w_n6, w_s;
    logic w_co;

    assign w_n1 = ~(r_a_sh[0] & r_b_sh[0]);
    assign w_n2 = ~(r_a_sh[0] & w_n1);
    assign w_n3 = ~(r_b_sh[0] & w_n1);
    assign w_s1 = ~(w_n2 & w_n3);
    assign w_n4 = ~(w_s1 & r_carry);
    assign w_n5 = ~(w_s1 & w_n4);
    assign w_n6 = ~(r_carry & w_n4);
    assign w_s  = ~(w_n5 & w_n6);
    assign w_co = ~(w_n1 & w_n4);

    // Ripple incrementer so the counter needs no arithmetic operator.
    always_comb begin
        logic w_c;
        w_cnt_inc = '0;
        w_c       = 1'b1;
        for (int i = 0; i < CW; i++) begin
            w_cnt_inc[i] = r_cnt[i] ^ w_c;
            w_c          = w_c & r_cnt[i];
        end
    end

    always_comb begin
        w_sum_nxt            = r_sum >> 1;
        w_sum_nxt[WIDTH-1]   = w_s;
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = start ? ADD : IDLE;
            ADD:     w_next = (r_cnt == LAST) ? DONE : ADD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ADD: begin
                    r_sum   <= w_sum_nxt;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_co;
                    r_cnt   <= w_cnt_inc;
                end
                default: ;
            endcase
        end
    end

    assign sum   = r_sum;
    assign carry = r_carry;
    assign busy  = (r_state == ADD);
    assign done  = (r_state == DONE);

endmodule
